// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared SRAM definitions used by the read sequencer, its sense amplifiers
// and the column write driver.
//   VDD / VSS : rail voltages used for real-valued data (volts)
//   VTH       : logic threshold used by the write side when mapping levels
//   rd_state_t: read sequencer state encoding (also exported for debug)
//   rail_of() : maps a logic bit onto its rail voltage
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  // Fixed encoding so the state can be matched against in waveforms/checkers.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    DEV   = 3'd2,
    SENSE = 3'd3,
    VALID = 3'd4
  } rd_state_t;

  function automatic real rail_of(input logic b);
    return b ? VDD : VSS;
  endfunction

endpackage

// File: rtl/sram_sense_amp.sv
// -----------------------------------------------------------------------------
// sram_sense_amp
// Combinational model of one column sense amplifier. Resolves the
// differential bitline pair into a bit and flags a differential too weak to
// trust. Holds no state; the sequencer latches the result.
//   i_bl    : true bitline voltage
//   i_blb   : complement bitline voltage
//   o_bit   : 1 when bl exceeds blb by at least VDIFF_MIN, else 0
//   o_weak  : 1 when |bl - blb| < VDIFF_MIN (o_bit is then 0)
// -----------------------------------------------------------------------------
module sram_sense_amp #(
  parameter real VDIFF_MIN = 0.1
) (
  input  real  i_bl,
  input  real  i_blb,
  output logic o_bit,
  output logic o_weak
);

  real w_diff;

  assign w_diff = i_bl - i_blb;

  always_comb begin
    o_bit  = 1'b0;
    o_weak = 1'b0;
    if (w_diff >= VDIFF_MIN) begin
      o_bit = 1'b1;
    end else if (w_diff > -VDIFF_MIN) begin
      // Neither side has developed far enough: report 0 and raise the flag.
      o_weak = 1'b1;
    end
  end

endmodule

// File: rtl/sram_read_sequencer.sv
// -----------------------------------------------------------------------------
// sram_read_sequencer
// Sequences one column-array read: bitline precharge, wordline evaluate,
// sense-amp strobe, then latch and hold the result until acknowledged.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rd_req / req_ready  : request side. A read starts on any edge where both
//                         are high; req_ready is high only in IDLE, so rd_req
//                         has no effect in any other state.
//   data_valid / rd_ack : result side. The result is consumed on any edge
//                         where both are high; data_valid then drops. The
//                         latched data stays on the outputs until the next
//                         sense.
//   bl_rd, blb_rd       : real bitline pair per column, sampled only on the
//                         edge that leaves SENSE
//   pre_en, wl_en, sae  : precharge, wordline and sense-amp strobes
//   data_out            : latched data as rail voltages (VDD / VSS)
//   data_bits           : latched data as logic, column 0 is the LSB
//   rd_err              : per-column weak-differential flag
//   dbg_state           : current FSM state
// -----------------------------------------------------------------------------
module sram_read_sequencer
  import sram_pkg::*;
#(
  parameter int  COLS       = 8,
  parameter int  PRE_CYCLES = 2,
  parameter int  DEV_CYCLES = 3,
  parameter real VDIFF_MIN  = 0.1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  output logic            req_ready,
  input  real             bl_rd  [0:COLS-1],
  input  real             blb_rd [0:COLS-1],
  output logic            pre_en,
  output logic            wl_en,
  output logic            sae,
  output real             data_out [0:COLS-1],
  output logic [COLS-1:0] data_bits,
  output logic [COLS-1:0] rd_err,
  output logic            data_valid,
  input  logic            rd_ack,
  output rd_state_t       dbg_state
);

  localparam int MAX_CYC = (PRE_CYCLES > DEV_CYCLES) ? PRE_CYCLES : DEV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  if (PRE_CYCLES < 1 || DEV_CYCLES < 1) begin : g_bad_params
    $error("sram_read_sequencer: PRE_CYCLES and DEV_CYCLES must both be >= 1");
  end

  rd_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [COLS-1:0] r_bits;
  logic [COLS-1:0] r_err;
  real             r_data_out [0:COLS-1];

  logic [COLS-1:0] w_bit;
  logic [COLS-1:0] w_weak;

  for (genvar g = 0; g < COLS; g++) begin : g_col
    sram_sense_amp #(
      .VDIFF_MIN (VDIFF_MIN)
    ) u_sense_amp (
      .i_bl   (bl_rd[g]),
      .i_blb  (blb_rd[g]),
      .o_bit  (w_bit[g]),
      .o_weak (w_weak[g])
    );
  end

  // The counter is loaded with (duration - 1) on entry, so a phase lasts
  // exactly its programmed number of clocks including the entry cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_err   <= '0;
      for (int i = 0; i < COLS; i++) begin
        r_data_out[i] <= VSS;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (rd_req) begin
            r_state <= PRE;
            r_cnt   <= CW'(PRE_CYCLES - 1);
          end
        end
        PRE: begin
          if (r_cnt == '0) begin
            r_state <= DEV;
            r_cnt   <= CW'(DEV_CYCLES - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DEV: begin
          if (r_cnt == '0) begin
            r_state <= SENSE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SENSE: begin
          // The only edge where the bitlines matter.
          r_state <= VALID;
          r_bits  <= w_bit;
          r_err   <= w_weak;
          for (int i = 0; i < COLS; i++) begin
            r_data_out[i] <= rail_of(w_bit[i]);
          end
        end
        VALID: begin
          // A request arriving together with the ack is dropped on purpose;
          // it must be re-presented once req_ready is back.
          if (rd_ack) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register, so PRE and DEV/SENSE
  // can never overlap and sae is always inside the wordline window.
  assign req_ready  = (r_state == IDLE);
  assign pre_en     = (r_state == PRE);
  assign wl_en      = (r_state == DEV) || (r_state == SENSE);
  assign sae        = (r_state == SENSE);
  assign data_valid = (r_state == VALID);
  assign data_bits  = r_bits;
  assign rd_err     = r_err;
  assign dbg_state  = r_state;

  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      data_out[i] = r_data_out[i];
    end
  end

endmodule

// File: tb/tb_sram_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_read_sequencer
// Two sequencers share one clock and reset: dut 0 with default timing (2/3),
// dut 1 with the minimum timing (1/1). A timeline model tracks, per dut,
// whether a read is in flight and how many edges have passed since it was
// accepted; every output is derived from that age every cycle.
// -----------------------------------------------------------------------------
module tb_sram_read_sequencer;
  import sram_pkg::*;

  localparam int  COLS = 8;
  localparam int  NDUT = 2;
  localparam int  P0   = 2;
  localparam int  D0   = 3;
  localparam int  P1   = 1;
  localparam int  D1   = 1;
  localparam real VMIN = 0.1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic            req   [NDUT];
  logic            ack   [NDUT];
  logic            rdy   [NDUT];
  logic            pre   [NDUT];
  logic            wl    [NDUT];
  logic            sae   [NDUT];
  logic            vld   [NDUT];
  logic [COLS-1:0] bits  [NDUT];
  logic [COLS-1:0] err   [NDUT];
  rd_state_t       st    [NDUT];
  real             bl0   [0:COLS-1];
  real             blb0  [0:COLS-1];
  real             bl1   [0:COLS-1];
  real             blb1  [0:COLS-1];
  real             dout0 [0:COLS-1];
  real             dout1 [0:COLS-1];

  sram_read_sequencer #(
    .COLS(COLS), .PRE_CYCLES(P0), .DEV_CYCLES(D0), .VDIFF_MIN(VMIN)
  ) u_dut0 (
    .clk(clk), .rst(rst), .rd_req(req[0]), .req_ready(rdy[0]),
    .bl_rd(bl0), .blb_rd(blb0), .pre_en(pre[0]), .wl_en(wl[0]), .sae(sae[0]),
    .data_out(dout0), .data_bits(bits[0]), .rd_err(err[0]),
    .data_valid(vld[0]), .rd_ack(ack[0]), .dbg_state(st[0])
  );

  sram_read_sequencer #(
    .COLS(COLS), .PRE_CYCLES(P1), .DEV_CYCLES(D1), .VDIFF_MIN(VMIN)
  ) u_dut1 (
    .clk(clk), .rst(rst), .rd_req(req[1]), .req_ready(rdy[1]),
    .bl_rd(bl1), .blb_rd(blb1), .pre_en(pre[1]), .wl_en(wl[1]), .sae(sae[1]),
    .data_out(dout1), .data_bits(bits[1]), .rd_err(err[1]),
    .data_valid(vld[1]), .rd_ack(ack[1]), .dbg_state(st[1])
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [COLS-1:0] exp_q[$];   // expected data_bits of each directed read, in order

  function automatic void chk(input string nm, input int d,
                              input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at t=%0t", nm, d, act, expv, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic int p_of(input int d); return (d == 0) ? P0 : P1; endfunction
  function automatic int d_of(input int d); return (d == 0) ? D0 : D1; endfunction
  function automatic real bl_of(input int d, input int i);
    return (d == 0) ? bl0[i] : bl1[i];
  endfunction
  function automatic real blb_of(input int d, input int i);
    return (d == 0) ? blb0[i] : blb1[i];
  endfunction
  function automatic real dout_of(input int d, input int i);
    return (d == 0) ? dout0[i] : dout1[i];
  endfunction

  logic            m_busy [NDUT];
  int              m_age  [NDUT];   // edges since the accept edge (0 = accept edge)
  logic [COLS-1:0] m_bits [NDUT];
  logic [COLS-1:0] m_err  [NDUT];
  real             m_df;

  // Timeline: ages 0..P-1 precharge, P..P+D-1 develop, P+D sense,
  // beyond that the result is held until acknowledged.
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
        m_age[d]  = 0;
        m_bits[d] = '0;
        m_err[d]  = '0;
      end else if (!m_busy[d]) begin
        if (req[d]) begin
          m_busy[d] = 1'b1;
          m_age[d]  = 0;
        end
      end else if (m_age[d] <= p_of(d) + d_of(d)) begin
        if (m_age[d] == p_of(d) + d_of(d)) begin
          for (int i = 0; i < COLS; i++) begin
            m_df         = bl_of(d, i) - blb_of(d, i);
            m_bits[d][i] = (m_df >= VMIN);
            m_err[d][i]  = (m_df < VMIN) && (m_df > -VMIN);
          end
        end
        m_age[d] = m_age[d] + 1;
      end else if (ack[d]) begin
        m_busy[d] = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        int        a;
        int        pp;
        int        dd;
        rd_state_t es;
        logic [2*COLS-1:0] act_rail;
        logic [2*COLS-1:0] exp_rail;
        a  = m_age[d];
        pp = p_of(d);
        dd = d_of(d);
        if (!m_busy[d])     es = IDLE;
        else if (a < pp)    es = PRE;
        else if (a < pp+dd) es = DEV;
        else if (a == pp+dd) es = SENSE;
        else                es = VALID;
        chk("req_ready",  d, rdy[d], !m_busy[d]);
        chk("pre_en",     d, pre[d], m_busy[d] && (a < pp));
        chk("wl_en",      d, wl[d],  m_busy[d] && (a >= pp) && (a <= pp + dd));
        chk("sae",        d, sae[d], m_busy[d] && (a == pp + dd));
        chk("data_valid", d, vld[d], m_busy[d] && (a > pp + dd));
        chk("state",      d, 64'(st[d]), 64'(es));
        chk("data_bits",  d, bits[d], m_bits[d]);
        chk("rd_err",     d, err[d],  m_err[d]);
        for (int i = 0; i < COLS; i++) begin
          real v;
          v = dout_of(d, i);
          act_rail[2*i +: 2] = (v == VDD) ? 2'd1 : ((v == VSS) ? 2'd0 : 2'd2);
          exp_rail[2*i +: 2] = m_bits[d][i] ? 2'd1 : 2'd0;
        end
        chk("data_out",    d, act_rail, exp_rail);
        chk("inv_pre_wl",  d, pre[d] & wl[d], 1'b0);
        chk("inv_sae_wl",  d, sae[d] & ~wl[d], 1'b0);
        chk("inv_rdy_vld", d, rdy[d] & vld[d], 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_col(input int d, input int i, input real b, input real bb);
    if (d == 0) begin bl0[i] = b; blb0[i] = bb; end
    else        begin bl1[i] = b; blb1[i] = bb; end
  endtask

  task automatic set_alt(input int d);
    for (int i = 0; i < COLS; i++) begin
      if (i % 2 == 0) set_col(d, i, 1.5, 0.4);
      else            set_col(d, i, 0.4, 1.5);
    end
  endtask

  task automatic set_all(input int d, input logic v);
    for (int i = 0; i < COLS; i++) begin
      if (v) set_col(d, i, 1.5, 0.0);
      else   set_col(d, i, 0.0, 1.5);
    end
  endtask

  // Pulses rd_req for one edge; t is the index of the accept edge.
  task automatic start_read(input int d, output int t);
    @(posedge clk); #1;
    req[d] = 1'b1;
    t = int'(cyc) + 1;
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  // which: 0 = data_valid, 1 = wl_en. Returns at the negedge where it is seen.
  task automatic wait_sig(input int d, input int which, output int edge_idx);
    logic found;
    found = 1'b0;
    edge_idx = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((which == 0) ? vld[d] : wl[d]) begin
        found = 1'b1;
        edge_idx = int'(cyc);
        break;
      end
    end
    chk((which == 0) ? "wait_valid" : "wait_wl", d, found, 1'b1);
  endtask

  task automatic do_ack(input int d);
    @(posedge clk); #1;
    ack[d] = 1'b1;
    @(posedge clk); #1;
    ack[d] = 1'b0;
  endtask

  task automatic check_result(input int d, input string nm, input logic [COLS-1:0] e_err);
    logic [COLS-1:0] e;
    e = exp_q.pop_front();
    chk(nm, d, bits[d], e);
    chk({nm, "_err"}, d, err[d], e_err);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  real lv [0:6] = '{0.0, 0.4, 0.75, 0.8, 0.85, 1.1, 1.5};

  initial begin
    int t;
    int e;
    int e1;
    int e2;
    int rises;
    logic prev;
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0;
      ack[d] = 1'b0;
      set_alt(d);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_bits",  0, bits[0], 8'h00);
    chk("reset_ready", 0, rdy[0], 1'b1);
    chk("reset_out0",  0, (dout0[0] == 0.0), 1'b1);

    // Basic read of alternating 1/0.
    set_alt(0);
    exp_q.push_back(8'h55);
    start_read(0, t);
    wait_sig(0, 0, e);
    chk("latency_default", 0, e - t, 6);
    check_result(0, "basic_bits", 8'h00);
    chk("basic_rail0", 0, (dout0[0] == 1.5) && (dout0[1] == 0.0), 1'b1);
    do_ack(0);
    @(negedge clk);
    chk("ack_ready", 0, rdy[0], 1'b1);

    // Weak differential on column 3.
    set_col(0, 3, 0.80, 0.75);
    exp_q.push_back(8'h55);
    start_read(0, t);
    wait_sig(0, 0, e);
    check_result(0, "weak_bits", 8'h08);

    // Held result: no ack for 10 cycles, req pulses ignored, bitlines wiggled.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      req[0] = k[0];
      set_all(0, k[0]);
    end
    req[0] = 1'b0;
    @(negedge clk);
    chk("held_valid", 0, vld[0], 1'b1);
    chk("held_ready", 0, rdy[0], 1'b0);
    chk("held_bits",  0, bits[0], 8'h55);
    // Ack together with a request: request must be dropped.
    @(posedge clk); #1;
    ack[0] = 1'b1;
    req[0] = 1'b1;
    @(posedge clk); #1;
    ack[0] = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    chk("ack_req_idle", 0, 64'(st[0]), 64'(IDLE));
    chk("ack_req_bits", 0, bits[0], 8'h55);

    // Reset during DEV.
    set_alt(0);
    start_read(0, t);
    wait_sig(0, 1, e);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 0, {pre[0], wl[0], sae[0]}, 3'b000);
    chk("rst_valid",   0, vld[0], 1'b0);
    chk("rst_state",   0, 64'(st[0]), 64'(IDLE));
    exp_q.push_back(8'h55);
    start_read(0, t);
    wait_sig(0, 0, e);
    chk("latency_after_rst", 0, e - t, 6);
    check_result(0, "after_rst_bits", 8'h00);
    do_ack(0);

    // Bitline sampling: change during DEV, hold across SENSE, change after.
    set_alt(0);
    exp_q.push_back(8'hFF);
    start_read(0, t);
    wait_sig(0, 1, e);
    set_all(0, 1'b1);
    wait_sig(0, 0, e);
    set_all(0, 1'b0);
    repeat (2) @(negedge clk);
    check_result(0, "sample_bits", 8'h00);
    do_ack(0);

    // Minimum timing on dut 1.
    set_alt(1);
    start_read(1, t);
    wait_sig(1, 0, e);
    chk("latency_min", 1, e - t, 3);
    do_ack(1);
    @(posedge clk); #1;
    req[1] = 1'b1;
    ack[1] = 1'b1;
    rises = 0;
    e1 = 0;
    e2 = 0;
    prev = vld[1];
    for (int k = 0; k < 40 && rises < 2; k++) begin
      @(negedge clk);
      if (vld[1] && !prev) begin
        if (rises == 0) e1 = int'(cyc);
        else            e2 = int'(cyc);
        rises++;
      end
      prev = vld[1];
    end
    chk("b2b_rises",  1, rises, 2);
    chk("b2b_period", 1, e2 - e1, 5);
    @(posedge clk); #1;
    req[1] = 1'b0;
    ack[1] = 1'b0;

    // Randomized traffic on both duts, bitlines changing every cycle.
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < NDUT; d++) begin
        req[d] = ($urandom_range(0, 3) == 0);
        ack[d] = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < COLS; i++) begin
          set_col(d, i, lv[$urandom_range(0, 6)], lv[$urandom_range(0, 6)]);
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0;
      ack[d] = 1'b1;
    end
    repeat (12) @(negedge clk);
    chk("final_idle0", 0, rdy[0], 1'b1);
    chk("final_idle1", 1, rdy[1], 1'b1);
    chk("queue_empty", 0, exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
